datapath_gen: RTL and testbench
===============================

# datapath_gen

Parametrised second-generation SLC3 datapath: the same register-transfer structure (PC, IR, MAR, MDR, register file, CC/BEN, LED) generalised in data width and register count. It adds an integrated memory-access sequencer with configurable wait states and a sticky bus-contention detector. It sits between the control FSM (cpu) and the memory/IO interface and replaces the fixed 16-bit datapath.

## Interface
- W, 16: data/address width; must be ≥ 16 (instruction fields are taken from IR[15:0]).
- NREG_LG, 3: log2 of register count; register specifiers are IR fields zero-extended or truncated to NREG_LG bits.
- LED_W, 10: LED register width; loaded from IR[LED_W-1:0]; must be ≤ 12.
- MEM_WAIT, 2: wait cycles between memory request and data valid (0 allowed).
- RESET_VEC, 0: PC reset value; also the PCMUX=3 source.

Ports:
- Clk  in  1  sole clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers; at most one asserted per cycle.
- SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN  in  1 each  mux selects.
- PCMUX, ADDR2MUX, ALUK  in  2 each  mux selects / ALU op.
- MEM_RD, MEM_WR  in  1 each  one-cycle memory request pulses from the control FSM.
- MDR_In  in  W  read data from memory.
- MAR, MDR, PC, IR  out  W  architectural registers.
- LED  out  LED_W  LED register.
- BEN  out  1  branch enable.
- MEM_OE, MEM_WE  out  1 each  memory strobes.
- MEM_RDY  out  1  one-cycle pulse: access complete.
- BUS_ERR  out  1  sticky contention flag.

## Operation
- Bus: the single asserted gate drives the bus (PC, MDR, ADDR1+ADDR2, ALU). With zero gates asserted, the bus is 0. With two or more gates asserted, the bus is 0 and BUS_ERR sets; BUS_ERR stays set until Reset.
- SR2MUX=1 selects the imm5 operand; otherwise SR2. ADDR2MUX: 0→0, 1→sext(IR[5:0]), 2→sext(IR[8:0]), 3→sext(IR[10:0]). All sign extension is from the field MSB to W.
- PCMUX: 0→PC+1, 1→ADDR1+ADDR2, 2→bus, 3→RESET_VEC. All arithmetic is modulo 2^W and wraps silently.
- ALUK: 0 ADD, 1 AND, 2 NOT A, 3 PASS A.
- CC_next is computed from the bus: 100 if negative (bus[W-1]), 010 if zero, 001 otherwise. BEN_next = |(IR[11:9] & CC).
- DRMUX=1 selects register all-ones (R7 when NREG_LG=3); otherwise IR[11:9]. SR1MUX=1 selects IR[8:6]; otherwise IR[11:9]. Register file reads are combinational.
- Memory sequencer states: IDLE, WAIT, DONE.
  - IDLE + MEM_RD: go to WAIT and assert MEM_OE. IDLE + MEM_WR: go to WAIT and assert MEM_WE. Load counter with MEM_WAIT.
  - If MEM_RD and MEM_WR arrive together, the read wins.
  - WAIT: the counter decrements each cycle; at 0 the sequencer goes to DONE. Strobes are held throughout WAIT.
  - DONE: MEM_RDY=1 for one cycle. On a read with MIO_EN=1, MDR loads MDR_In regardless of LD_MDR. The sequencer then returns to IDLE.
  - Requests arriving in WAIT or DONE are ignored.
  - The external LD_MDR loads MDR in any state.

## Timing
- Reset values: PC=RESET_VEC; IR, MAR, MDR, all registers, CC, LED = 0; BEN=0; BUS_ERR=0; sequencer IDLE with MEM_OE/MEM_WE/MEM_RDY = 0.
- Reset asserted mid-access aborts the access. Strobes drop asynchronously and no MEM_RDY is produced.
- Register loads take effect on the edge after the enable is sampled. Register file writes are visible to reads on the next cycle (no bypass).
- Memory latency: a request sampled at edge n produces MEM_RDY high during cycle n+MEM_WAIT+1. MDR updates at the edge ending that cycle.
- With MEM_WAIT=0, MEM_RDY is asserted during cycle n+1.
- BUS_ERR rises on the edge after the contention cycle.

## Structure
- Package datapath_pkg holds: mem_state_t enum (IDLE/WAIT/DONE); ALUK, PCMUX and ADDR2MUX encodings as localparams; CC encodings.
- Sub-module mem_seq contains the sequencer FSM and wait counter ($clog2(MEM_WAIT+1) bits, minimum 1).
- Reuse the existing parametrised register, mux2_1/mux4_1, ALU and regfile modules (regfile widened to W/NREG_LG).

## Test plan
- Reset with RESET_VEC=16'h3000 → PC=3000; all other outputs 0. Apply PCMUX=0 and LD_PC for 3 cycles → PC=3003.
- W=16, set PC=FFFF, then PCMUX=0 with LD_PC → PC=0000 (wrap).
- MEM_WAIT=2: MEM_RD at edge 0 with MDR_In=ABCD and MIO_EN=1 → MEM_OE high during cycles 1–3, MEM_RDY only in cycle 3, MDR=ABCD after edge 3.
  - A second MEM_RD in cycle 2 is ignored.
  - Repeat with MEM_WAIT=0 → MEM_RDY in cycle 1.
- GatePC and GateALU high together for one cycle → bus=0, BUS_ERR=1 from the next edge and held. Reset → BUS_ERR=0.
- IR=0x0E05 (BR nzp), bus=8000 with LD_CC, then LD_BEN → CC=100, BEN=1. IR=0x0205 → BEN=0.
- W=32, IR=0x01F0, ADDR2MUX=2, ADDR1MUX=0 with PC=0x10, GateMARMUX and LD_MAR → MAR=0x00000000 (0x10 + sext 0x1F0 = 0x10 − 0x10).
  - Reset asserted during the WAIT state → strobes drop immediately and no MEM_RDY appears.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the parametrised SLC3 datapath and its
// memory-access sequencer.
package datapath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] ALUK_ADD  = 2'd0;
  localparam logic [1:0] ALUK_AND  = 2'd1;
  localparam logic [1:0] ALUK_NOT  = 2'd2;
  localparam logic [1:0] ALUK_PASS = 2'd3;

  localparam logic [1:0] PCMUX_INC  = 2'd0;
  localparam logic [1:0] PCMUX_ADDR = 2'd1;
  localparam logic [1:0] PCMUX_BUS  = 2'd2;
  localparam logic [1:0] PCMUX_RST  = 2'd3;

  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

endpackage

// File: rtl/datapath_gen_if.sv
// Control/status bundle between the control FSM (master) and datapath_gen (slave).
interface datapath_gen_if #(
  parameter int W     = 16,
  parameter int LED_W = 10
);
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  // Memory handshake: MEM_RD/MEM_WR are single-cycle request pulses accepted
  // only while the sequencer is IDLE (read wins if both); MEM_OE/MEM_WE hold
  // until completion, and MEM_RDY pulses for exactly one cycle to mark it.
  logic MEM_RD, MEM_WR;
  logic [W-1:0] MDR_In;
  logic [W-1:0] MAR, MDR, PC, IR;
  logic [LED_W-1:0] LED;
  logic BEN, MEM_OE, MEM_WE, MEM_RDY, BUS_ERR;
  logic [2:0] cc;
  datapath_pkg::mem_state_t seq_state;

  modport master (
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN, PCMUX, ADDR2MUX, ALUK,
    output MEM_RD, MEM_WR, MDR_In,
    input  MAR, MDR, PC, IR, LED, BEN, MEM_OE, MEM_WE, MEM_RDY, BUS_ERR,
    input  cc, seq_state
  );

  modport slave (
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN, PCMUX, ADDR2MUX, ALUK,
    input  MEM_RD, MEM_WR, MDR_In,
    output MAR, MDR, PC, IR, LED, BEN, MEM_OE, MEM_WE, MEM_RDY, BUS_ERR,
    output cc, seq_state
  );
endinterface

// File: rtl/datapath_gen_mem_seq.sv
// Memory-access sequencer: IDLE -> WAIT (MEM_WAIT cycles) -> DONE, with
// registered strobes held from acceptance until the DONE cycle ends.
module mem_seq
  import datapath_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_rd,
  input  logic       mem_wr,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       mem_rdy,
  output mem_state_t state
);
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_oe  <= 1'b0;
      mem_we  <= 1'b0;
      mem_rdy <= 1'b0;
    end else begin
      mem_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rd || mem_wr) begin
            mem_oe <= mem_rd;
            mem_we <= !mem_rd;
            cnt    <= CW'(MEM_WAIT);
            if (MEM_WAIT == 0) begin
              state   <= DONE;
              mem_rdy <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        // cnt counts the WAIT cycles still owed, including the current one
        WAIT: begin
          if (cnt <= CW'(1)) begin
            state   <= DONE;
            mem_rdy <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          mem_oe <= 1'b0;
          mem_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/datapath_gen.sv
// Parametrised SLC3 datapath: PC/IR/MAR/MDR, register file, CC/BEN, LED,
// single shared bus with contention detection and an integrated memory sequencer.
module datapath_gen
  import datapath_pkg::*;
#(
  parameter int             W         = 16,
  parameter int             NREG_LG   = 3,
  parameter int             LED_W     = 10,
  parameter int             MEM_WAIT  = 2,
  parameter logic [W-1:0]   RESET_VEC = '0
) (
  input logic           Clk,
  input logic           Reset,
  datapath_gen_if.slave dp
);
  localparam int NREG = 1 << NREG_LG;

  logic [W-1:0]       pc_q, ir_q, mar_q, mdr_q;
  logic [LED_W-1:0]   led_q;
  logic [2:0]         cc_q;
  logic               ben_q, bus_err_q;
  logic [W-1:0]       regs [NREG];

  logic [NREG_LG-1:0] sr1_sel, sr2_sel, dr_sel;
  logic [W-1:0]       sr1_val, sr2_val, imm5, alu_b, alu_out;
  logic [W-1:0]       addr1, addr2, addr_sum, bus, pc_next;
  logic [2:0]         cc_next;
  logic               contention, mdr_fill;
  logic               seq_oe, seq_we, seq_rdy;
  logic               unused_ir;

  assign unused_ir = ^ir_q[W-1:12];

  always_comb begin
    sr1_sel  = dp.SR1MUX ? NREG_LG'(ir_q[8:6]) : NREG_LG'(ir_q[11:9]);
    sr2_sel  = NREG_LG'(ir_q[2:0]);
    dr_sel   = dp.DRMUX ? '1 : NREG_LG'(ir_q[11:9]);
    sr1_val  = regs[sr1_sel];
    sr2_val  = regs[sr2_sel];
    imm5     = {{(W-5){ir_q[4]}}, ir_q[4:0]};
    alu_b    = dp.SR2MUX ? imm5 : sr2_val;
    case (dp.ALUK)
      ALUK_ADD: alu_out = sr1_val + alu_b;
      ALUK_AND: alu_out = sr1_val & alu_b;
      ALUK_NOT: alu_out = ~sr1_val;
      default:  alu_out = sr1_val;
    endcase
    addr1 = dp.ADDR1MUX ? sr1_val : pc_q;
    case (dp.ADDR2MUX)
      ADDR2_ZERO: addr2 = '0;
      ADDR2_OFF6: addr2 = {{(W-6){ir_q[5]}}, ir_q[5:0]};
      ADDR2_OFF9: addr2 = {{(W-9){ir_q[8]}}, ir_q[8:0]};
      default:    addr2 = {{(W-11){ir_q[10]}}, ir_q[10:0]};
    endcase
    addr_sum = addr1 + addr2;
  end

  // Multiple drivers collapse the bus to zero rather than picking a winner
  always_comb begin
    contention = $countones({dp.GatePC, dp.GateMDR, dp.GateALU, dp.GateMARMUX}) > 1;
    bus        = '0;
    if (!contention) begin
      if (dp.GatePC)          bus = pc_q;
      else if (dp.GateMDR)    bus = mdr_q;
      else if (dp.GateALU)    bus = alu_out;
      else if (dp.GateMARMUX) bus = addr_sum;
    end
    if (bus[W-1])       cc_next = CC_N;
    else if (bus == '0) cc_next = CC_Z;
    else                cc_next = CC_P;
    case (dp.PCMUX)
      PCMUX_INC:  pc_next = pc_q + W'(1);
      PCMUX_ADDR: pc_next = addr_sum;
      PCMUX_BUS:  pc_next = bus;
      default:    pc_next = RESET_VEC;
    endcase
  end

  mem_seq #(.MEM_WAIT(MEM_WAIT)) u_mem_seq (
    .clk     (Clk),
    .rst     (Reset),
    .mem_rd  (dp.MEM_RD),
    .mem_wr  (dp.MEM_WR),
    .mem_oe  (seq_oe),
    .mem_we  (seq_we),
    .mem_rdy (seq_rdy),
    .state   (dp.seq_state)
  );

  // A completing read captures memory data even without LD_MDR
  assign mdr_fill = seq_rdy && seq_oe && dp.MIO_EN;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q      <= RESET_VEC;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      led_q     <= '0;
      cc_q      <= '0;
      ben_q     <= 1'b0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (dp.LD_PC)             pc_q  <= pc_next;
      if (dp.LD_IR)             ir_q  <= bus;
      if (dp.LD_MAR)            mar_q <= bus;
      if (dp.LD_MDR || mdr_fill) mdr_q <= dp.MIO_EN ? dp.MDR_In : bus;
      if (dp.LD_LED)            led_q <= ir_q[LED_W-1:0];
      if (dp.LD_CC)             cc_q  <= cc_next;
      if (dp.LD_BEN)            ben_q <= |(ir_q[11:9] & cc_q);
      if (dp.LD_REG)            regs[dr_sel] <= bus;
      if (contention)           bus_err_q <= 1'b1;
    end
  end

  assign dp.PC      = pc_q;
  assign dp.IR      = ir_q;
  assign dp.MAR     = mar_q;
  assign dp.MDR     = mdr_q;
  assign dp.LED     = led_q;
  assign dp.BEN     = ben_q;
  assign dp.BUS_ERR = bus_err_q;
  assign dp.cc      = cc_q;
  assign dp.MEM_OE  = seq_oe;
  assign dp.MEM_WE  = seq_we;
  assign dp.MEM_RDY = seq_rdy;
endmodule

// File: tb/tb_datapath_gen.sv
// Directed and randomized checks of datapath_gen: a 16-bit instance with two
// wait states and a 32-bit instance with zero wait states.
module tb_datapath_gen;
  logic Clk;
  logic Reset;

  int n_checks;
  int n_errors;

  logic [15:0] m_reg [8];
  logic [15:0] m_pc;
  logic [15:0] ir, v, a_val, b_val, exp_res, exp_addr;
  logic [2:0]  exp_cc, dr, s1idx;
  logic [1:0]  aluk, a2;
  logic        s1, s2, drm, a1, saw_rdy;

  datapath_gen_if #(.W(16), .LED_W(10)) d_if ();
  datapath_gen_if #(.W(32), .LED_W(10)) e_if ();

  datapath_gen #(
    .W(16), .NREG_LG(3), .LED_W(10), .MEM_WAIT(2), .RESET_VEC(16'h3000)
  ) u_d (
    .Clk   (Clk),
    .Reset (Reset),
    .dp    (d_if.slave)
  );

  datapath_gen #(
    .W(32), .NREG_LG(3), .LED_W(10), .MEM_WAIT(0), .RESET_VEC(32'h0)
  ) u_e (
    .Clk   (Clk),
    .Reset (Reset),
    .dp    (e_if.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_d();
    {d_if.LD_MAR, d_if.LD_MDR, d_if.LD_IR, d_if.LD_BEN, d_if.LD_CC, d_if.LD_REG,
     d_if.LD_PC, d_if.LD_LED, d_if.GatePC, d_if.GateMDR, d_if.GateALU, d_if.GateMARMUX,
     d_if.SR2MUX, d_if.ADDR1MUX, d_if.DRMUX, d_if.SR1MUX, d_if.MIO_EN,
     d_if.PCMUX, d_if.ADDR2MUX, d_if.ALUK, d_if.MEM_RD, d_if.MEM_WR, d_if.MDR_In} = '0;
  endtask

  task automatic clear_e();
    {e_if.LD_MAR, e_if.LD_MDR, e_if.LD_IR, e_if.LD_BEN, e_if.LD_CC, e_if.LD_REG,
     e_if.LD_PC, e_if.LD_LED, e_if.GatePC, e_if.GateMDR, e_if.GateALU, e_if.GateMARMUX,
     e_if.SR2MUX, e_if.ADDR1MUX, e_if.DRMUX, e_if.SR1MUX, e_if.MIO_EN,
     e_if.PCMUX, e_if.ADDR2MUX, e_if.ALUK, e_if.MEM_RD, e_if.MEM_WR, e_if.MDR_In} = '0;
  endtask

  task automatic d_load_mdr(input logic [15:0] val);
    d_if.MDR_In = val; d_if.MIO_EN = 1'b1; d_if.LD_MDR = 1'b1;
    tick(); clear_d();
  endtask

  task automatic d_load_ir(input logic [15:0] val);
    d_load_mdr(val);
    d_if.GateMDR = 1'b1; d_if.LD_IR = 1'b1;
    tick(); clear_d();
  endtask

  task automatic e_load_mdr(input logic [31:0] val);
    e_if.MDR_In = val; e_if.MIO_EN = 1'b1; e_if.LD_MDR = 1'b1;
    tick(); clear_e();
  endtask

  task automatic e_load_ir(input logic [31:0] val);
    e_load_mdr(val);
    e_if.GateMDR = 1'b1; e_if.LD_IR = 1'b1;
    tick(); clear_e();
  endtask

  function automatic logic [15:0] sext(input logic [15:0] val, input int bits);
    logic [15:0] mask;
    mask = 16'hFFFF << bits;
    return val[bits-1] ? (val | mask) : (val & ~mask);
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] val);
    if (val[15]) return 3'b100;
    if (val == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    clear_d();
    clear_e();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pc", d_if.PC, 32'h3000);
    check("rst_mar", d_if.MAR, 0);
    check("rst_mdr", d_if.MDR, 0);
    check("rst_ir", d_if.IR, 0);
    check("rst_led", d_if.LED, 0);
    check("rst_strobes", {d_if.BEN, d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY, d_if.BUS_ERR}, 0);
    check("rst_cc", d_if.cc, 0);
    check("rst_e_pc", e_if.PC, 0);
    Reset = 1'b0;

    // PC increment and wrap
    d_if.PCMUX = 2'd0; d_if.LD_PC = 1'b1;
    repeat (3) tick();
    clear_d();
    check("pc_inc3", d_if.PC, 32'h3003);
    d_load_mdr(16'hFFFF);
    d_if.GateMDR = 1'b1; d_if.PCMUX = 2'd2; d_if.LD_PC = 1'b1;
    tick(); clear_d();
    check("pc_from_bus", d_if.PC, 32'hFFFF);
    d_if.LD_PC = 1'b1;
    tick(); clear_d();
    check("pc_wrap", d_if.PC, 0);

    // Read with two wait states; a request during the access is ignored
    d_if.MIO_EN = 1'b1; d_if.MDR_In = 16'hABCD; d_if.MEM_RD = 1'b1;
    tick(); d_if.MEM_RD = 1'b0;
    check("rd_c1", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b100);
    tick();
    check("rd_c2", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b100);
    d_if.MEM_RD = 1'b1;
    tick(); d_if.MEM_RD = 1'b0;
    check("rd_c3", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b101);
    check("rd_c3_mdr", d_if.MDR, 32'hFFFF);
    tick();
    check("rd_c4", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b000);
    check("rd_c4_mdr", d_if.MDR, 32'hABCD);
    tick();
    check("rd_ignored", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b000);
    clear_d();

    // Write, then simultaneous read+write
    d_if.MDR_In = 16'h1234; d_if.MEM_WR = 1'b1;
    tick(); d_if.MEM_WR = 1'b0;
    check("wr_c1", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b010);
    tick(); tick();
    check("wr_c3", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b011);
    tick();
    check("wr_c4", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b000);
    check("wr_mdr_kept", d_if.MDR, 32'hABCD);
    d_if.MEM_RD = 1'b1; d_if.MEM_WR = 1'b1;
    tick(); clear_d();
    check("rdwr_read_wins", {d_if.MEM_OE, d_if.MEM_WE}, 2'b10);
    repeat (3) tick();

    // Reset during WAIT aborts the access
    d_if.MIO_EN = 1'b1; d_if.MDR_In = 16'h5555; d_if.MEM_RD = 1'b1;
    tick(); d_if.MEM_RD = 1'b0;
    check("abort_c1_oe", d_if.MEM_OE, 1);
    #2 Reset = 1'b1;
    #1;
    check("abort_async", {d_if.MEM_OE, d_if.MEM_WE, d_if.MEM_RDY}, 3'b000);
    #2 Reset = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_rdy = saw_rdy | d_if.MEM_RDY | d_if.MEM_OE;
    end
    clear_d();
    check("abort_no_rdy", saw_rdy, 0);
    check("abort_mdr", d_if.MDR, 0);

    // Bus contention
    d_if.GatePC = 1'b1; d_if.LD_MAR = 1'b1;
    tick(); clear_d();
    check("mar_pc", d_if.MAR, 32'h3000);
    check("no_err", d_if.BUS_ERR, 0);
    d_if.GatePC = 1'b1; d_if.GateALU = 1'b1; d_if.LD_MAR = 1'b1;
    tick(); clear_d();
    check("contention_bus0", d_if.MAR, 0);
    check("contention_err", d_if.BUS_ERR, 1);
    tick(); tick();
    check("err_sticky", d_if.BUS_ERR, 1);
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    check("err_cleared", d_if.BUS_ERR, 0);

    // CC, BEN and LED
    d_load_ir(16'h0E05);
    d_load_mdr(16'h8000);
    d_if.GateMDR = 1'b1; d_if.LD_CC = 1'b1;
    tick(); clear_d();
    check("cc_neg", d_if.cc, 3'b100);
    d_if.LD_BEN = 1'b1;
    tick(); clear_d();
    check("ben_nzp", d_if.BEN, 1);
    d_if.LD_LED = 1'b1;
    tick(); clear_d();
    check("led", d_if.LED, 10'h205);
    d_load_ir(16'h0205);
    d_if.LD_BEN = 1'b1;
    tick(); clear_d();
    check("ben_p_only", d_if.BEN, 0);

    // Seed the register file, then run random ALU and address operations
    m_pc = 16'h3000;
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      d_load_ir(16'(i << 9));
      d_load_mdr(v);
      d_if.GateMDR = 1'b1; d_if.LD_REG = 1'b1;
      tick(); clear_d();
      m_reg[i] = v;
    end
    for (int k = 0; k < 40; k++) begin
      ir   = 16'($urandom);
      aluk = 2'($urandom_range(0, 3));
      s1   = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      drm  = 1'($urandom_range(0, 1));
      d_load_ir(ir);
      s1idx = s1 ? ir[8:6] : ir[11:9];
      a_val = m_reg[s1idx];
      b_val = s2 ? sext(ir, 5) : m_reg[ir[2:0]];
      case (aluk)
        2'd0:    exp_res = a_val + b_val;
        2'd1:    exp_res = a_val & b_val;
        2'd2:    exp_res = ~a_val;
        default: exp_res = a_val;
      endcase
      exp_cc = cc_of(exp_res);
      dr = drm ? 3'd7 : ir[11:9];
      d_if.ALUK = aluk; d_if.SR1MUX = s1; d_if.SR2MUX = s2; d_if.DRMUX = drm;
      d_if.GateALU = 1'b1; d_if.LD_REG = 1'b1; d_if.LD_MAR = 1'b1; d_if.LD_CC = 1'b1;
      tick(); clear_d();
      check("alu_result", d_if.MAR, exp_res);
      check("alu_cc", d_if.cc, exp_cc);
      m_reg[dr] = exp_res;
      d_if.LD_BEN = 1'b1;
      tick(); clear_d();
      check("alu_ben", d_if.BEN, |(ir[11:9] & exp_cc));
      a1 = 1'($urandom_range(0, 1));
      a2 = 2'($urandom_range(0, 3));
      case (a2)
        2'd0:    exp_addr = 16'h0;
        2'd1:    exp_addr = sext(ir, 6);
        2'd2:    exp_addr = sext(ir, 9);
        default: exp_addr = sext(ir, 11);
      endcase
      exp_addr = exp_addr + (a1 ? m_reg[s1idx] : m_pc);
      d_if.SR1MUX = s1; d_if.ADDR1MUX = a1; d_if.ADDR2MUX = a2;
      d_if.GateMARMUX = 1'b1; d_if.LD_MAR = 1'b1;
      tick(); clear_d();
      check("addr_sum", d_if.MAR, exp_addr);
    end

    // 32-bit instance: zero-wait read and wide sign extension
    e_if.MIO_EN = 1'b1; e_if.MDR_In = 32'h1234_5678; e_if.MEM_RD = 1'b1;
    tick(); e_if.MEM_RD = 1'b0;
    check("w0_c1", {e_if.MEM_OE, e_if.MEM_WE, e_if.MEM_RDY}, 3'b101);
    tick(); clear_e();
    check("w0_c2", {e_if.MEM_OE, e_if.MEM_WE, e_if.MEM_RDY}, 3'b000);
    check("w0_mdr", e_if.MDR, 32'h1234_5678);
    e_load_ir(32'h01F0);
    e_load_mdr(32'h10);
    e_if.GateMDR = 1'b1; e_if.PCMUX = 2'd2; e_if.LD_PC = 1'b1;
    tick(); clear_e();
    check("w32_pc", e_if.PC, 32'h10);
    e_if.GatePC = 1'b1; e_if.LD_MAR = 1'b1;
    tick(); clear_e();
    check("w32_mar_pc", e_if.MAR, 32'h10);
    e_if.ADDR2MUX = 2'd2; e_if.GateMARMUX = 1'b1; e_if.LD_MAR = 1'b1;
    tick(); clear_e();
    check("w32_off9", e_if.MAR, 32'h0);
    e_if.ADDR2MUX = 2'd3; e_if.GateMARMUX = 1'b1; e_if.LD_MAR = 1'b1;
    tick(); clear_e();
    check("w32_off11", e_if.MAR, 32'h200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
